// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer: owns the PC, fetches over a read/waitrequest port,
// presents instructions to execute, and applies MIPS branch-delay-slot ordering.
// Optional macro PC_SEQ_ALIGN_CHECK_EN adds a sticky misaligned-target fault.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_read,
    output logic [31:0] instr_address,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        exec_ready,
    input  logic        redirect,
    input  logic [31:0] pcnext,
    output logic        in_delay_slot,
    output logic        active
`ifdef PC_SEQ_ALIGN_CHECK_EN
    ,
    output logic        fault
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] target_q, target_d;
    logic        ds_q, ds_d;
    logic        read_q, read_d;
    logic        valid_q, valid_d;
    logic        active_q, active_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic        fault_q, fault_d;
`endif

    logic [31:0] pc_inc;
    logic [31:0] target_in;

    assign pc_inc = pc_q + 32'd4;

`ifdef PC_SEQ_ALIGN_CHECK_EN
    // Keep the raw target so the delay-slot acceptance can flag misalignment.
    assign target_in = pcnext;
`else
    assign target_in = pcnext & ~32'h3;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        target_d = target_q;
        ds_d     = ds_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        fault_d  = fault_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (!instr_waitrequest) begin
                    instr_d = instr_readdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (exec_ready) begin
                    // A redirect on a delay-slot instruction is dropped: the
                    // older pending target always wins.
                    if (ds_q && target_q == HALT_ADDR) begin
                        state_d = S_HALTED;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                    end else if (ds_q && target_q[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_HALTED;
`endif
                    end else if (ds_q) begin
                        pc_d    = target_q;
                        ds_d    = 1'b0;
                        state_d = S_FETCH;
                    end else if (redirect) begin
                        target_d = target_in;
                        pc_d     = pc_inc;
                        ds_d     = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
        read_d   = (state_d == S_FETCH);
        valid_d  = (state_d == S_ISSUE);
        active_d = (state_d == S_FETCH) || (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_VECTOR;
            instr_q  <= 32'd0;
            target_q <= 32'd0;
            ds_q     <= 1'b0;
            read_q   <= 1'b0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            target_q <= target_d;
            ds_q     <= ds_d;
            read_q   <= read_d;
            valid_q  <= valid_d;
            active_q <= active_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            fault_q  <= fault_d;
`endif
        end
    end

    assign instr_read    = read_q;
    assign instr_address = pc_q;
    assign instr_valid   = valid_q;
    assign instr         = instr_q;
    assign pc            = pc_q;
    assign in_delay_slot = ds_q;
    assign active        = active_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    assign fault         = fault_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of issue steps plus a fetch-address scoreboard.
module tb_pc_sequencer;
    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_read;
    logic [31:0] instr_address;
    logic        instr_waitrequest = 1'b0;
    logic [31:0] instr_readdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exec_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] pcnext = 32'd0;
    logic        in_delay_slot;
    logic        active;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic        fault;
`endif

    pc_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_read        (instr_read),
        .instr_address     (instr_address),
        .instr_waitrequest (instr_waitrequest),
        .instr_readdata    (instr_readdata),
        .instr_valid       (instr_valid),
        .instr             (instr),
        .pc                (pc),
        .exec_ready        (exec_ready),
        .redirect          (redirect),
        .pcnext            (pcnext),
        .in_delay_slot     (in_delay_slot),
        .active            (active)
`ifdef PC_SEQ_ALIGN_CHECK_EN
        ,
        .fault             (fault)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          wait_left = 0;
    logic        in_wait = 1'b0;
    logic [31:0] held_addr = 32'd0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    assign instr_readdata = mem(instr_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model + scoreboard: waits wait_left cycles, then compares address.
    always @(negedge clk) begin
        if (instr_read && wait_left > 0) begin
            if (in_wait) chk("addr_hold", instr_address, held_addr);
            instr_waitrequest = 1'b1;
            wait_left--;
            held_addr = instr_address;
            in_wait = 1'b1;
        end else begin
            if (in_wait && instr_read) chk("addr_hold", instr_address, held_addr);
            in_wait = 1'b0;
            instr_waitrequest = 1'b0;
            if (instr_read) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch: got %h expected none", instr_address);
                end else begin
                    chk("fetch_addr", instr_address, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic [31:0] exp_pc, input logic exp_ds, input logic rd,
                        input logic [31:0] tgt, input logic [31:0] exp_next,
                        input logic halts, input int stall);
        int n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got no instr_valid expected pc %h", exp_pc);
            return;
        end
        chk("pc", pc, exp_pc);
        chk("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, exp_ds});
        chk("instr", instr, mem(exp_pc));
        for (int i = 0; i < stall; i++) begin
            exec_ready = 1'b0;
            redirect = 1'b1;
            pcnext = $urandom;
            @(negedge clk);
            chk("stall_pc", pc, exp_pc);
            chk("stall_instr", instr, mem(exp_pc));
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        exec_ready = 1'b1;
        redirect = rd;
        pcnext = tgt;
        if (!halts) exp_q.push_back(exp_next);
        @(negedge clk);
        exec_ready = 1'b0;
        redirect = 1'b0;
        pcnext = 32'd0;
        if (halts) begin
            chk("halt_active", {31'd0, active}, 32'd0);
            chk("halt_read", {31'd0, instr_read}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        end else begin
            chk("read_after_accept", {31'd0, instr_read}, 32'd1);
        end
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic        exp_ds;
        logic [31:0] exp_next;
    } vec_t;

    vec_t tab[9];

    initial begin
        tab[0] = '{1'b0, 32'd0,         RV + 32'h00,  1'b0, RV + 32'h04};
        tab[1] = '{1'b0, 32'd0,         RV + 32'h04,  1'b0, RV + 32'h08};
        tab[2] = '{1'b0, 32'd0,         RV + 32'h08,  1'b0, RV + 32'h0C};
        tab[3] = '{1'b0, 32'd0,         RV + 32'h0C,  1'b0, RV + 32'h10};
        tab[4] = '{1'b1, RV + 32'h100,  RV + 32'h10,  1'b0, RV + 32'h14};
        tab[5] = '{1'b0, 32'd0,         RV + 32'h14,  1'b1, RV + 32'h100};
        tab[6] = '{1'b1, RV + 32'h400,  RV + 32'h100, 1'b0, RV + 32'h104};
        tab[7] = '{1'b1, RV + 32'h800,  RV + 32'h104, 1'b1, RV + 32'h400};
        tab[8] = '{1'b1, RV + 32'h102,  RV + 32'h400, 1'b0, RV + 32'h404};

        // Reset values
        @(negedge clk);
        chk("rst_read", {31'd0, instr_read}, 32'd0);
        chk("rst_addr", instr_address, RV);
        chk("rst_pc", pc, RV);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ds", {31'd0, in_delay_slot}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
`ifdef PC_SEQ_ALIGN_CHECK_EN
        chk("rst_fault", {31'd0, fault}, 32'd0);
`endif
        exp_q.push_back(RV);
        rst_n = 1'b1;
        @(negedge clk);
        chk("active_after_rst", {31'd0, active}, 32'd1);
        chk("first_read", {31'd0, instr_read}, 32'd1);
        @(negedge clk);
        chk("issue_after_fetch", {31'd0, instr_valid}, 32'd1);

        for (int i = 0; i < 9; i++)
            step(tab[i].exp_pc, tab[i].exp_ds, tab[i].rd, tab[i].tgt, tab[i].exp_next, 1'b0, 0);
`ifdef PC_SEQ_ALIGN_CHECK_EN
        step(RV + 32'h404, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 0);
        chk("fault_set", {31'd0, fault}, 32'd1);
        repeat (2) @(negedge clk);
        chk("fault_sticky", {31'd0, fault}, 32'd1);
`else
        step(RV + 32'h404, 1'b1, 1'b0, 32'd0, RV + 32'h100, 1'b0, 0);
        step(RV + 32'h100, 1'b0, 1'b0, 32'd0, RV + 32'h104, 1'b0, 0);
`endif

        // Waited first fetch, stall, wrap, halt after delay slot
        #2 rst_n = 1'b0;
        exp_q.delete();
        wait_left = 0;
        in_wait = 1'b0;
        @(negedge clk);
        wait_left = 3;
        exp_q.push_back(RV);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("wait_read", {31'd0, instr_read}, 32'd1);
            chk("wait_addr", instr_address, RV);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        @(negedge clk);
        chk("valid_cycle5", {31'd0, instr_valid}, 32'd1);
        step(RV,            1'b0, 1'b1, 32'hFFFF_FFFC, RV + 32'h4,    1'b0, 2);
        step(RV + 32'h4,    1'b1, 1'b0, 32'd0,         32'hFFFF_FFFC, 1'b0, 0);
        step(32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0,         32'h0,         1'b0, 0);
        step(32'h0,         1'b0, 1'b1, RV + 32'h20,   32'h4,         1'b0, 0);
        step(32'h4,         1'b1, 1'b0, 32'd0,         RV + 32'h20,   1'b0, 0);
        step(RV + 32'h20,   1'b0, 1'b1, 32'h0,         RV + 32'h24,   1'b0, 0);
        step(RV + 32'h24,   1'b1, 1'b0, 32'd0,         32'd0,         1'b1, 0);
        exec_ready = 1'b1;
        redirect = 1'b1;
        pcnext = RV;
        repeat (3) @(negedge clk);
        chk("halted_read", {31'd0, instr_read}, 32'd0);
        chk("halted_active", {31'd0, active}, 32'd0);
        exec_ready = 1'b0;
        redirect = 1'b0;

        // Asynchronous reset during a waited delay-slot fetch
        #2 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        exp_q.push_back(RV);
        rst_n = 1'b1;
        for (int n = 0; n < 10 && !instr_valid; n++) @(negedge clk);
        wait_left = 4;
        step(RV, 1'b0, 1'b1, RV + 32'h100, RV + 32'h4, 1'b0, 0);
        @(negedge clk);
        chk("mid_wait_read", {31'd0, instr_read}, 32'd1);
        chk("mid_wait_ds", {31'd0, in_delay_slot}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_read", {31'd0, instr_read}, 32'd0);
        chk("async_addr", instr_address, RV);
        chk("async_instr", instr, 32'd0);
        chk("async_ds", {31'd0, in_delay_slot}, 32'd0);
        chk("async_active", {31'd0, active}, 32'd0);
        chk("async_valid", {31'd0, instr_valid}, 32'd0);
        exp_q.delete();
        wait_left = 0;
        in_wait = 1'b0;
        @(negedge clk);
        exp_q.push_back(RV);
        rst_n = 1'b1;
        step(RV,         1'b0, 1'b0, 32'd0, RV + 32'h4, 1'b0, 0);
        step(RV + 32'h4, 1'b0, 1'b0, 32'd0, RV + 32'h8, 1'b0, 0);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
